// File: rtl/weight_ram_loader.sv
// Run-time loader for the signed weight memory: writes a valid/ready coefficient stream
// row-major into a DEPTH x COLL RAM and serves the same registered row/collum read port as the ROM.
module weight_ram_loader #(
  parameter  int WIDTH     = 5,
  parameter  int COLL      = 8,
  parameter  int DEPTH     = 37,
  localparam int DEPTH_LOG = $clog2(DEPTH),
  localparam int COLL_LOG  = $clog2(COLL)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 s_ready,
  output logic                 busy,
  output logic                 done,
  output logic [DEPTH_LOG-1:0] wr_row,
  output logic [COLL_LOG-1:0]  wr_col,
  input  logic [DEPTH_LOG-1:0] row,
  input  logic [COLL_LOG-1:0]  collum,
  output logic [WIDTH-1:0]     data_out
);

  localparam int TOTAL  = DEPTH * COLL;
  localparam int ADDR_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state_reg, state_next;
  logic [DEPTH_LOG-1:0] wr_row_reg, wr_row_next;
  logic [COLL_LOG-1:0]  wr_col_reg, wr_col_next;
  logic                 we;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_in_range;
  logic                 last_beat;

  logic [WIDTH-1:0] mem [TOTAL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wr_row_reg <= '0;
      wr_col_reg <= '0;
    end else begin
      state_reg  <= state_next;
      wr_row_reg <= wr_row_next;
      wr_col_reg <= wr_col_next;
    end
  end

  assign last_beat = (wr_row_reg == DEPTH_LOG'(DEPTH - 1)) && (wr_col_reg == COLL_LOG'(COLL - 1));

  always_comb begin
    state_next  = state_reg;
    wr_row_next = wr_row_reg;
    wr_col_next = wr_col_reg;
    we          = 1'b0;
    s_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: ;
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        // A restart wins over a beat arriving in the same cycle, so that beat is dropped.
        if (s_valid && !start) begin
          we = 1'b1;
          if (last_beat) begin
            wr_row_next = '0;
            wr_col_next = '0;
            state_next  = DONE;
          end else if (wr_col_reg == COLL_LOG'(COLL - 1)) begin
            wr_col_next = '0;
            wr_row_next = wr_row_reg + DEPTH_LOG'(1);
          end else begin
            wr_col_next = wr_col_reg + COLL_LOG'(1);
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (start) begin
      wr_row_next = '0;
      wr_col_next = '0;
      state_next  = LOAD;
    end
  end

  assign wr_addr     = ADDR_W'(wr_row_reg) * ADDR_W'(COLL) + ADDR_W'(wr_col_reg);
  assign rd_addr     = ADDR_W'(row) * ADDR_W'(COLL) + ADDR_W'(collum);
  assign rd_in_range = ({1'b0, row} < (DEPTH_LOG + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= s_data;
    end
  end

  // Read and write share an edge, so a same-address read returns the previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_in_range) begin
      data_out <= mem[rd_addr];
    end else begin
      data_out <= '0;
    end
  end

  assign wr_row = wr_row_reg;
  assign wr_col = wr_col_reg;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Directed bench for weight_ram_loader: stimulus pushes expected read data into a queue,
// a negedge monitor pops and compares whenever a read result is due.
module tb_weight_ram_loader;
  localparam int TOTAL = 296;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [4:0] s_data = '0;
  logic       s_ready, busy, done;
  logic [5:0] wr_row;
  logic [2:0] wr_col;
  logic [5:0] row = '0;
  logic [2:0] collum = '0;
  logic [4:0] data_out;

  logic       rd_en = 1'b0;
  logic       rd_pend = 1'b0;
  logic [4:0] sb_q[$];
  logic [4:0] model[TOTAL];
  int         mptr = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         exp_done = 0;

  weight_ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .busy(busy), .done(done), .wr_row(wr_row), .wr_col(wr_col),
    .row(row), .collum(collum), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_en;

  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rd_pend) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("data_out", {27'b0, data_out}, {27'b0, e});
          $display("read row=%0d col=%0d data_out=%0h expected=%0h", row, collum, data_out, e);
        end
      end
    end
  end

  function automatic logic [4:0] beat_val(input int mode, input int i);
    logic [4:0] v;
    v = 5'(i % 32);
    if (mode == 1 && i == 0) v = 5'b10000;
    if (mode == 1 && i == TOTAL - 1) v = 5'b01111;
    if (mode == 2) v = 5'(i * 3 + 1);
    if (mode == 3 && i == 19) v = 5'd3;
    if (mode == 4 && i == 19) v = 5'd7;
    if (mode == 5) v = 5'(i + 7);
    return v;
  endfunction

  task automatic pulse_start(input bit with_beat);
    s_valid = with_beat;
    s_data  = 5'h15;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
    mptr    = 0;
    $display("start pulse beat_during=%0d wr_row=%0d wr_col=%0d busy=%0d", with_beat, wr_row, wr_col, busy);
  endtask

  task automatic load(input int n, input int mode, input bit gaps, input int rd_beat);
    for (int i = 0; i < n; i++) begin
      logic [4:0] v;
      int w;
      int g;
      v = beat_val(mode, i);
      g = 0;
      while (gaps && g < 4 && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b0;
        s_data  = ~v;
        chk("ready_in_gap", {31'b0, s_ready}, 1);
        @(posedge clk); #1;
        g++;
      end
      chk("wr_row", {26'b0, wr_row}, mptr / 8);
      chk("wr_col", {29'b0, wr_col}, mptr % 8);
      s_valid = 1'b1;
      s_data  = v;
      if (i == rd_beat) begin
        row = 6'd2; collum = 3'd3; rd_en = 1'b1;
        sb_q.push_back(model[19]);
      end
      w = 0;
      while (!s_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (!s_ready) begin
        chk("ready_timeout", 0, 1);
        s_valid = 1'b0;
        rd_en   = 1'b0;
        return;
      end
      @(posedge clk); #1;
      rd_en   = 1'b0;
      s_valid = 1'b0;
      model[mptr] = v;
      mptr++;
      if (mptr == TOTAL) begin
        mptr = 0;
        exp_done++;
        chk("done_pulse", {31'b0, done}, 1);
        chk("busy_in_done", {31'b0, busy}, 0);
        chk("ready_in_done", {31'b0, s_ready}, 0);
        @(posedge clk); #1;
        chk("done_low", {31'b0, done}, 0);
        chk("done_count", done_cnt, exp_done);
        $display("load complete mode=%0d done_cnt=%0d", mode, done_cnt);
      end
    end
  endtask

  task automatic rd1(input int r, input int c, input logic [4:0] e);
    row = 6'(r); collum = 3'(c); rd_en = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read_all(input bit formula);
    for (int r = 0; r < 37; r++) begin
      for (int c = 0; c < 8; c++) begin
        row = 6'(r); collum = 3'(c); rd_en = 1'b1;
        sb_q.push_back(formula ? 5'((r * 8 + c) % 32) : model[r * 8 + c]);
        @(posedge clk); #1;
      end
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, s_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_wr_row", {26'b0, wr_row}, 0);
    chk("rst_wr_col", {29'b0, wr_col}, 0);
    chk("rst_data_out", {27'b0, data_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) back-to-back load of i mod 32
    pulse_start(1'b0);
    load(TOTAL, 0, 1'b0, -1);
    read_all(1'b1);

    // 2) same image with random valid gaps
    pulse_start(1'b0);
    load(TOTAL, 0, 1'b1, -1);
    read_all(1'b1);

    // 3) extreme signed values at first and last cells, out-of-range rows
    pulse_start(1'b0);
    load(TOTAL, 1, 1'b0, -1);
    rd1(0, 0, 5'b10000);
    rd1(36, 7, 5'b01111);
    rd1(37, 0, 5'd0);
    rd1(63, 7, 5'd0);
    rd1(1, 2, 5'd10);

    // 4) restart after 100 beats, with a beat offered in the restart cycle
    pulse_start(1'b0);
    load(100, 2, 1'b0, -1);
    pulse_start(1'b1);
    chk("restart_wr_row", {26'b0, wr_row}, 0);
    chk("restart_wr_col", {29'b0, wr_col}, 0);
    chk("restart_busy", {31'b0, busy}, 1);
    load(TOTAL, 5, 1'b0, -1);
    chk("restart_done_count", done_cnt, exp_done);
    read_all(1'b0);

    // 5) reset in the middle of a load
    pulse_start(1'b0);
    load(50, 2, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_ready", {31'b0, s_ready}, 0);
    chk("midrst_wr_row", {26'b0, wr_row}, 0);
    chk("midrst_wr_col", {29'b0, wr_col}, 0);
    chk("midrst_data_out", {27'b0, data_out}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", {31'b0, busy}, 0);
    chk("midrst_no_done", done_cnt, exp_done);
    $display("mid-load reset busy=%0d done_cnt=%0d", busy, done_cnt);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 2; c++)
        rd1(r, c, model[r * 8 + c]);

    // 6) read-before-write collision at (2,3)
    pulse_start(1'b0);
    load(TOTAL, 3, 1'b0, -1);
    pulse_start(1'b0);
    load(TOTAL, 4, 1'b0, 19);
    rd1(2, 3, 5'd7);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
